wb_dmem_responder: RTL and testbench

- Wishbone classic slave memory model that sits directly downstream of the CPU data bus (dbus) in simulation and formal benches.
- Stores words in an internal array and generates ack/err after a configurable number of wait states, plus an externally driven stall.
- Applies byte-lane writes and returns read data only in the ack cycle.
- Gives the dmem consistency harness a concrete, protocol-correct memory to run against, in place of free-running random ack/data.

---
 rtl/wb_dmem_responder.sv | 134 +++++++++++++
 tb/tb_wb_dmem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wb_dmem_responder.sv
// Wishbone classic slave memory model for the dbus: wait states, stall, byte-lane writes, err on out-of-range.
// Define WB_DMEM_PROTOCOL_CHECK_EN to compile in master-side protocol assertions.
module wb_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic        stall,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          capture;
  logic [29:0]   idx;
  logic          in_range;
  logic          wr_en;

  logic [AW-1:0] idx_p0;
  logic          we_p0;
  logic [3:0]    sel_p0;
  logic [31:0]   dat_p0;
  logic          inr_p0;

  logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

  assign idx      = wb_adr - BASE_WORD;
  assign in_range = idx < 30'(DEPTH_WORDS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the WAIT cycles still owed, including the current one, so the
  // response lands exactly WAIT_STATES unstalled cycles after acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wb_cyc && wb_stb) begin
          capture   = 1'b1;
          cnt_nxt   = WAIT_CNT;
          state_nxt = (WAIT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!wb_cyc) begin
          state_nxt = ST_IDLE;
        end else if (!stall) begin
          if (cnt <= 4'd1) state_nxt = ST_RESP;
          else             cnt_nxt   = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture: the response and the write use only these fields.
  always_ff @(posedge clock) begin
    if (capture) begin
      idx_p0 <= idx[AW-1:0];
      we_p0  <= wb_we;
      sel_p0 <= wb_sel;
      dat_p0 <= wb_dat_w;
      inr_p0 <= in_range;
    end
  end

  // Response cycle: read data is the pre-write contents of the word.
  assign wb_ack   = (state == ST_RESP) && inr_p0;
  assign wb_err   = (state == ST_RESP) && !inr_p0;
  assign wb_dat_r = wb_ack ? mem[idx_p0] : '0;
  assign wr_en    = wb_ack && wb_cyc && wb_stb && we_p0 && !reset;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_p0[n]) mem[idx_p0][8*n +: 8] <= dat_p0[8*n +: 8];
      end
    end
  end

`ifdef WB_DMEM_PROTOCOL_CHECK_EN
  logic [29:0] adr_p0;
  logic        resp_prev;

  always_ff @(posedge clock) begin
    if (capture) adr_p0 <= wb_adr;
    if (reset) resp_prev <= 1'b0;
    else       resp_prev <= wb_ack || wb_err;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!wb_stb || wb_cyc)
        else $fatal(1, "wb_dmem_responder: stb without cyc");
      assert (!(wb_ack && wb_err))
        else $fatal(1, "wb_dmem_responder: ack and err together");
      assert (!(resp_prev && (wb_ack || wb_err)))
        else $fatal(1, "wb_dmem_responder: responses in consecutive cycles");
      if (state == ST_WAIT && wb_cyc) begin
        assert (wb_adr == adr_p0 && wb_we == we_p0 && wb_sel == sel_p0 && wb_dat_w == dat_p0)
          else $fatal(1, "wb_dmem_responder: master changed request during wait");
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_dmem_responder.sv
// Directed bench for wb_dmem_responder: three instances with WAIT_STATES of 1, 2 and 0.
module tb_wb_dmem_responder;

  logic        clock;
  logic        reset;
  logic [29:0] adr   [3];
  logic [31:0] dat_w [3];
  logic [31:0] dat_r [3];
  logic [3:0]  sel   [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic        stall [3];
  logic        ack   [3];
  logic        err   [3];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wb_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_w1 (
    .clock(clock), .reset(reset), .wb_adr(adr[0]), .wb_dat_w(dat_w[0]), .wb_sel(sel[0]),
    .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .stall(stall[0]),
    .wb_dat_r(dat_r[0]), .wb_ack(ack[0]), .wb_err(err[0]));

  wb_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_w2 (
    .clock(clock), .reset(reset), .wb_adr(adr[1]), .wb_dat_w(dat_w[1]), .wb_sel(sel[1]),
    .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .stall(stall[1]),
    .wb_dat_r(dat_r[1]), .wb_ack(ack[1]), .wb_err(err[1]));

  wb_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_w0 (
    .clock(clock), .reset(reset), .wb_adr(adr[2]), .wb_dat_w(dat_w[2]), .wb_sel(sel[2]),
    .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we[2]), .stall(stall[2]),
    .wb_dat_r(dat_r[2]), .wb_ack(ack[2]), .wb_err(err[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; stall[d] = 1'b0;
  endtask

  // One transfer: request seen in cycle T, response expected at T+lat, stall high in T+1..T+nstall.
  task automatic xfer(input int d, input string tag, input logic w, input logic [29:0] a,
                      input logic [31:0] dw, input logic [3:0] s, input int lat, input int nstall,
                      input logic exp_ack, input logic [31:0] exp_dat);
    @(posedge clock); #1;
    adr[d] = a; dat_w[d] = dw; sel[d] = s; we[d] = w; cyc[d] = 1'b1; stb[d] = 1'b1;
    @(negedge clock);
    chk1({tag, "/resp_T"}, ack[d] | err[d], 1'b0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock); #1;
      stall[d] = (k <= nstall);
      @(negedge clock);
      if (k == lat) begin
        chk1({tag, "/ack"}, ack[d], exp_ack);
        chk1({tag, "/err"}, err[d], !exp_ack);
        chk32({tag, "/dat"}, dat_r[d], exp_dat);
      end else begin
        chk1({tag, "/early_resp"}, ack[d] | err[d], 1'b0);
        chk32({tag, "/early_dat"}, dat_r[d], 32'h0);
      end
    end
    @(posedge clock); #1;
    bus_idle(d);
    @(negedge clock);
    chk1({tag, "/after_resp"}, ack[d] | err[d], 1'b0);
    chk32({tag, "/after_dat"}, dat_r[d], 32'h0);
  endtask

  initial begin
    logic [3:0] b2b_ack;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      adr[d] = '0; dat_w[d] = '0; sel[d] = '0;
      bus_idle(d);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      chk1("reset/ack", ack[d], 1'b0);
      chk1("reset/err", err[d], 1'b0);
      chk32("reset/dat", dat_r[d], 32'h0);
    end

    // Basic write then read, one wait state
    xfer(0, "basic_wr", 1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 2, 0, 1'b1, 32'h0);
    xfer(0, "basic_rd", 1'b0, 30'h10, 32'h0, 4'hF, 2, 0, 1'b1, 32'hDEADBEEF);

    // Byte lanes
    xfer(0, "lane_wr_full", 1'b1, 30'h20, 32'h11223344, 4'hF, 2, 0, 1'b1, 32'h0);
    xfer(0, "lane_wr_0101", 1'b1, 30'h20, 32'hAABBCCDD, 4'b0101, 2, 0, 1'b1, 32'h11223344);
    xfer(0, "lane_rd", 1'b0, 30'h20, 32'h0, 4'hF, 2, 0, 1'b1, 32'h11BB33DD);
    xfer(0, "lane_wr_sel0", 1'b1, 30'h20, 32'hFFFFFFFF, 4'h0, 2, 0, 1'b1, 32'h11BB33DD);
    xfer(0, "lane_rd_sel0", 1'b0, 30'h20, 32'h0, 4'hF, 2, 0, 1'b1, 32'h11BB33DD);

    // Two wait states plus three stalled cycles: ack at T+6
    xfer(1, "stall_wr", 1'b1, 30'h30, 32'h0F0F0F0F, 4'hF, 6, 3, 1'b1, 32'h0);
    xfer(1, "stall_rd", 1'b0, 30'h30, 32'h0, 4'hF, 3, 0, 1'b1, 32'h0F0F0F0F);

    // Abort: cyc dropped during WAIT
    @(posedge clock); #1;
    adr[1] = 30'h30; dat_w[1] = 32'hFFFFFFFF; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clock); #1;
    bus_idle(1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk1("abort/no_resp", ack[1] | err[1], 1'b0);
      @(posedge clock);
    end
    xfer(1, "abort_rd", 1'b0, 30'h30, 32'h0, 4'hF, 3, 0, 1'b1, 32'h0F0F0F0F);

    // Out of range: word 1024 aliases word 0 in the low index bits
    xfer(0, "oor_pre_wr", 1'b1, 30'd0, 32'h01234567, 4'hF, 2, 0, 1'b1, 32'h0);
    xfer(0, "oor_wr", 1'b1, 30'd1024, 32'hFFFFFFFF, 4'hF, 2, 0, 1'b0, 32'h0);
    xfer(0, "oor_rd0", 1'b0, 30'd0, 32'h0, 4'hF, 2, 0, 1'b1, 32'h01234567);

    // Reset during WAIT of a write to word 5
    xfer(0, "rst_pre_wr", 1'b1, 30'd5, 32'h5A5A5A5A, 4'hF, 2, 0, 1'b1, 32'h0);
    @(posedge clock); #1;
    adr[0] = 30'd5; dat_w[0] = 32'hFFFF0000; sel[0] = 4'hF; we[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk1("rst/resp_T1", ack[0] | err[0], 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus_idle(0);
    @(negedge clock);
    chk1("rst/resp_T2", ack[0] | err[0], 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk1("rst/resp_T3", ack[0] | err[0], 1'b0);
    xfer(0, "rst_rd", 1'b0, 30'd5, 32'h0, 4'hF, 2, 0, 1'b1, 32'h5A5A5A5A);

    // Zero wait states, stb held across two reads: acks at T+1 and T+3
    xfer(2, "w0_wr", 1'b1, 30'd3, 32'hCAFEF00D, 4'hF, 1, 0, 1'b1, 32'h0);
    b2b_ack = 4'b1010;
    @(posedge clock); #1;
    adr[2] = 30'd3; sel[2] = 4'hF; we[2] = 1'b0; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(negedge clock);
    chk1("b2b/resp_T", ack[2] | err[2], 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk1("b2b/ack", ack[2], b2b_ack[k]);
      chk1("b2b/err", err[2], 1'b0);
      chk32("b2b/dat", dat_r[2], b2b_ack[k] ? 32'hCAFEF00D : 32'h0);
    end
    @(posedge clock); #1;
    bus_idle(2);
    @(negedge clock);
    chk1("b2b/after", ack[2] | err[2], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
